// File: rtl/sram_pkg.sv
// Shared types and constants for the Wishbone-to-asynchronous-SRAM slave.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH_DEF = 20;
  localparam int unsigned WAIT_CNT_WIDTH      = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    WRITE_HOLD,
    ACK,
    ERR
  } state_t;

endpackage

// File: rtl/wb_sram_slave.sv
// Wishbone classic-cycle slave driving an asynchronous 32-bit SRAM through registered pads.
// Define SRAM_RANGE_CHECK_EN to answer requests outside the BASE_ADDR window with wb_err_o.
module wb_sram_slave
  import sram_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEF,
  parameter int unsigned READ_WAIT       = 2,
  parameter int unsigned WRITE_WAIT      = 2,
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [31:0]                wb_adr_i,
  input  logic [31:0]                wb_dat_i,
  input  logic [3:0]                 wb_sel_i,
  output logic [31:0]                wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       wb_rty_o,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]                sram_data_o,
  input  logic [31:0]                sram_data_i,
  output logic                       sram_data_oe_o,
  output logic                       sram_ce_n_o,
  output logic                       sram_oe_n_o,
  output logic                       sram_we_n_o,
  output logic [3:0]                 sram_be_n_o
);

  localparam logic [WAIT_CNT_WIDTH-1:0] READ_LAST  = WAIT_CNT_WIDTH'(READ_WAIT - 1);
  localparam logic [WAIT_CNT_WIDTH-1:0] WRITE_LAST = WAIT_CNT_WIDTH'(WRITE_WAIT - 1);

  state_t                    state_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q;
  logic                      abort_q;
  logic                      req;
  logic                      unused_bits;

  assign req         = wb_cyc_i & wb_stb_i;
  assign wb_ack_o    = (state_q == ACK);
  assign wb_rty_o    = 1'b0;
  // Byte-offset bits and, without range checking, the upper address bits are don't-care.
  assign unused_bits = ^{wb_adr_i, BASE_ADDR};

`ifdef SRAM_RANGE_CHECK_EN
  localparam logic [32:0] WINDOW_BYTES = 33'd4 << SRAM_ADDR_WIDTH;

  logic [32:0] win_off;
  logic        in_window;

  // A borrow out of bit 32 means the address lies below BASE_ADDR.
  assign win_off   = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
  assign in_window = ~win_off[32] & (win_off < WINDOW_BYTES);
  assign wb_err_o  = (state_q == ERR);
`else
  assign wb_err_o  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      abort_q        <= 1'b0;
      wb_dat_o       <= '0;
      sram_addr_o    <= '0;
      sram_data_o    <= '0;
      sram_data_oe_o <= 1'b0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_be_n_o    <= 4'hF;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            wait_cnt_q <= '0;
            abort_q    <= 1'b0;
`ifdef SRAM_RANGE_CHECK_EN
            if (!in_window) begin
              state_q <= ERR;
            end else
`endif
            begin
              sram_addr_o <= wb_adr_i[SRAM_ADDR_WIDTH+1:2];
              sram_data_o <= wb_dat_i;
              sram_be_n_o <= ~wb_sel_i;
              if (!wb_we_i) begin
                sram_ce_n_o <= 1'b0;
                sram_oe_n_o <= 1'b0;
                state_q     <= READ;
              end else if (wb_sel_i == 4'b0000) begin
                state_q <= ACK;
              end else begin
                sram_ce_n_o    <= 1'b0;
                sram_data_oe_o <= 1'b1;
                sram_we_n_o    <= 1'b0;
                state_q        <= WRITE;
              end
            end
          end
        end

        READ: begin
          if (!wb_cyc_i) begin
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            state_q     <= IDLE;
          end else if (wait_cnt_q == READ_LAST) begin
            wb_dat_o    <= sram_data_i;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            state_q     <= ACK;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        // A dropped cycle is remembered but never shortens the we_n pulse.
        WRITE: begin
          if (!wb_cyc_i) begin
            abort_q <= 1'b1;
          end
          if (wait_cnt_q == WRITE_LAST) begin
            sram_we_n_o <= 1'b1;
            state_q     <= WRITE_HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        WRITE_HOLD: begin
          sram_ce_n_o    <= 1'b1;
          sram_data_oe_o <= 1'b0;
          state_q        <= (abort_q || !wb_cyc_i) ? IDLE : ACK;
        end

        ACK: begin
          state_q <= IDLE;
        end

`ifdef SRAM_RANGE_CHECK_EN
        ERR: begin
          state_q <= IDLE;
        end
`endif

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
